// File: rtl/portamento_sched_pkg.sv
// Shared constants for the portamento scheduler: slot timing, FSM encoding
// and the default pitch word width.
package portamento_sched_pkg;

  localparam int PORTA_DSZ  = 48;
  localparam int SLOT_LEN   = 4;
  localparam int SLOT_CNT_W = $clog2(SLOT_LEN);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sched_state_e;

endpackage

// File: rtl/portamento_sched_if.sv
// Update handshake and filter-side bus of the portamento scheduler.
// The host side drives updates and the enable; the scheduler side drives the filter.
interface portamento_sched_if
  import portamento_sched_pkg::*;
#(
  parameter int SEL_WIDTH = 2,
  parameter int DSZ       = PORTA_DSZ
);

  logic                 en;
  logic                 upd_req;
  logic [SEL_WIDTH-1:0] upd_unit;
  logic [DSZ-1:0]       upd_pitch;
  logic                 upd_ack;
  logic [SEL_WIDTH-1:0] unit;
  logic                 porta_tick;
  logic [DSZ-1:0]       pitch_out;
  logic                 sweep_done;
  logic                 overrun;

  modport master (
    output en, upd_req, upd_unit, upd_pitch,
    input  upd_ack, unit, porta_tick, pitch_out, sweep_done, overrun
  );

  modport slave (
    input  en, upd_req, upd_unit, upd_pitch,
    output upd_ack, unit, porta_tick, pitch_out, sweep_done, overrun
  );

endinterface

// File: rtl/portamento_sched_tick_prescaler.sv
// Free-running 0..PRESCALE-1 counter; tc is high for the single cycle the
// counter sits at its terminal value.
module tick_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tc
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/portamento_sched.sv
// Time-multiplexes one shared portamento filter across NCOMAX+1 units: each
// prescaler request triggers a sweep of 4-cycle slots presenting unit/pitch/tick.
module portamento_sched
  import portamento_sched_pkg::*;
#(
  parameter int SEL_WIDTH = 2,
  parameter int NCOMAX    = 3,
  parameter int DSZ       = PORTA_DSZ,
  parameter int PRESCALE  = 1000
) (
  input logic clk,
  input logic rst_n,
  portamento_sched_if.slave bus
);

  localparam int NUNITS = NCOMAX + 1;
  localparam logic [SEL_WIDTH-1:0]  LAST_UNIT = SEL_WIDTH'(NCOMAX);
  localparam logic [SLOT_CNT_W-1:0] SLOT_LAST = SLOT_CNT_W'(SLOT_LEN - 1);

  sched_state_e          state;
  logic [SLOT_CNT_W-1:0] slot_cnt;
  logic [SEL_WIDTH-1:0]  unit_q;
  logic [SEL_WIDTH-1:0]  next_unit;
  logic [DSZ-1:0]        pitch_q;
  logic [DSZ-1:0]        next_pitch;
  logic                  tick_q;
  logic                  done_q;
  logic                  pending;
  logic                  overrun_q;
  logic                  tc;
  logic                  start;
  logic                  upd_hits_active;
  logic                  upd_accept;
  logic                  upd_write;

  logic [DSZ-1:0]    table_mem [NUNITS];
  logic [NUNITS-1:0] entry_valid;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tc    (tc)
  );

  assign start           = (state == IDLE) && bus.en && (pending || tc);
  assign upd_hits_active = (state == SWEEP) && (bus.upd_unit == unit_q);
  assign upd_accept      = bus.upd_req && !upd_hits_active;
  assign upd_write       = upd_accept && (int'(bus.upd_unit) <= NCOMAX);

  // Plain RAM without reset; entry_valid makes cleared entries read as zero.
  always_ff @(posedge clk) begin
    if (upd_write) begin
      table_mem[bus.upd_unit] <= bus.upd_pitch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_valid <= '0;
    end else if (upd_write) begin
      entry_valid[bus.upd_unit] <= 1'b1;
    end
  end

  // A write landing on the same edge that opens the unit's slot is forwarded,
  // so pitch_out always equals the table contents for the whole slot.
  assign next_unit = (state == IDLE) ? '0 : unit_q + 1'b1;

  always_comb begin
    next_pitch = '0;
    if (upd_write && (bus.upd_unit == next_unit)) begin
      next_pitch = bus.upd_pitch;
    end else if (entry_valid[next_unit]) begin
      next_pitch = table_mem[next_unit];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      slot_cnt <= '0;
      unit_q   <= '0;
      pitch_q  <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SWEEP;
            slot_cnt <= '0;
            unit_q   <= next_unit;
            pitch_q  <= next_pitch;
            tick_q   <= 1'b1;
          end
        end
        SWEEP: begin
          if (slot_cnt != SLOT_LAST) begin
            slot_cnt <= slot_cnt + 1'b1;
          end else begin
            slot_cnt <= '0;
            if (unit_q == LAST_UNIT) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              unit_q  <= next_unit;
              pitch_q <= next_pitch;
              tick_q  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A start consumes the held request; a terminal count on that same edge
  // re-arms it instead of counting as an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (start) begin
      pending <= pending && tc;
    end else if (tc) begin
      pending <= 1'b1;
      if (pending) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.upd_ack    = upd_accept;
  assign bus.unit       = unit_q;
  assign bus.pitch_out  = pitch_q;
  assign bus.porta_tick = tick_q;
  assign bus.sweep_done = done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_portamento_sched.sv
// Self-checking bench for portamento_sched: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a sweep-position model.
module tb_portamento_sched;

  localparam int P_A = 20;
  localparam int P_B = 16;
  localparam int SWEEP_CYCLES = 16;

  typedef struct {
    int          cyc;
    bit          en;
    bit          req;
    logic [1:0]  uu;
    logic [47:0] up;
    bit          ack;
    logic [1:0]  unit;
    bit          tick;
    bit          done;
    logic [47:0] pitch;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  portamento_sched_if #(.SEL_WIDTH(2), .DSZ(48)) bus_a ();
  portamento_sched_if #(.SEL_WIDTH(2), .DSZ(48)) bus_b ();

  portamento_sched #(
    .SEL_WIDTH (2),
    .NCOMAX    (3),
    .DSZ       (48),
    .PRESCALE  (P_A)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (bus_a)
  );

  portamento_sched #(
    .SEL_WIDTH (2),
    .NCOMAX    (3),
    .DSZ       (48),
    .PRESCALE  (P_B)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  // Reference model state for dut_a: m_pos is the cycle offset inside the
  // current sweep, or -1 while idle.
  int          m_cyc;
  int          m_pos;
  bit          m_pending;
  bit          m_overrun;
  bit          m_tick;
  bit          m_done;
  logic [1:0]  m_unit;
  logic [47:0] m_pitch;
  logic [47:0] m_table [4];

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic applyStimulus(input bit en, input bit req, input logic [1:0] uu, input logic [47:0] up);
    bus_a.en        = en;
    bus_a.upd_req   = req;
    bus_a.upd_unit  = uu;
    bus_a.upd_pitch = up;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetA();
    rst_n_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n_a = 1'b1;
  endtask

  task automatic resetB();
    rst_n_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n_b = 1'b1;
  endtask

  task automatic modelReset();
    m_cyc = 0; m_pos = -1; m_pending = 0; m_overrun = 0;
    m_tick = 0; m_done = 0; m_unit = '0; m_pitch = '0;
    for (int i = 0; i < 4; i++) m_table[i] = '0;
  endtask

  function automatic bit modelAck(input bit req, input logic [1:0] uu);
    return req && ((m_pos < 0) || (int'(uu) != m_pos / 4));
  endfunction

  // One clock edge of the behavioural rules: table write, request
  // bookkeeping, and sweep position advance.
  task automatic modelEdge(input bit en, input bit ack, input logic [1:0] uu, input logic [47:0] up);
    bit tc;
    bit started;
    if (ack) m_table[uu] = up;
    tc = ((m_cyc % P_A) == P_A - 1);
    started = 0;
    m_tick = 0;
    m_done = 0;
    if (m_pos >= 0) begin
      m_pos++;
      if (m_pos == SWEEP_CYCLES) begin
        m_pos  = -1;
        m_done = 1;
      end
    end else if (en && (m_pending || tc)) begin
      m_pos   = 0;
      started = 1;
    end
    if (started) m_pending = m_pending && tc;
    else if (tc) begin
      if (m_pending) m_overrun = 1;
      m_pending = 1;
    end
    if (m_pos >= 0) begin
      m_unit  = 2'(m_pos / 4);
      m_tick  = ((m_pos % 4) == 0);
      m_pitch = m_table[m_unit];
    end
    m_cyc++;
  endtask

  function automatic vec_t mk(input int c, input bit e, input bit rq, input logic [1:0] uu,
                              input logic [47:0] up, input bit a, input logic [1:0] un,
                              input bit t, input bit d, input logic [47:0] p);
    vec_t v;
    v.cyc = c; v.en = e; v.req = rq; v.uu = uu; v.up = up;
    v.ack = a; v.unit = un; v.tick = t; v.done = d; v.pitch = p;
    return v;
  endfunction

  initial begin
    vec_t        vecs[$];
    int          vi;
    bit          cur_en;
    bit          cur_req;
    logic [1:0]  cur_uu;
    logic [47:0] cur_up;
    int          ticks;
    bit          found;
    int          waited;
    int          tick_cyc[$];
    int          done_cyc[$];
    int          exp_ticks[$];
    bit          r_en;
    bit          r_req;
    bit          e_ack;
    logic [1:0]  r_unit;
    logic [47:0] r_pitch;
    logic [47:0] P2;
    logic [47:0] P1;

    P2 = 48'h0000_1234_5678;
    P1 = 48'h0000_0000_ABCD;
    applyStimulus(1'b0, 1'b0, 2'd0, 48'd0);
    bus_b.en = 1'b0; bus_b.upd_req = 1'b0; bus_b.upd_unit = '0; bus_b.upd_pitch = '0;

    //        cyc en req uu     up  ack unit tick done pitch
    vecs.push_back(mk( 0, 1, 0, 2'd0, 48'd0, 0, 2'd0, 0, 0, 48'd0));
    vecs.push_back(mk(19, 1, 0, 2'd0, 48'd0, 0, 2'd0, 0, 0, 48'd0));
    vecs.push_back(mk(20, 1, 0, 2'd0, 48'd0, 0, 2'd0, 1, 0, 48'd0));
    vecs.push_back(mk(21, 1, 0, 2'd0, 48'd0, 0, 2'd0, 0, 0, 48'd0));
    vecs.push_back(mk(24, 1, 0, 2'd0, 48'd0, 0, 2'd1, 1, 0, 48'd0));
    vecs.push_back(mk(27, 1, 0, 2'd0, 48'd0, 0, 2'd1, 0, 0, 48'd0));
    vecs.push_back(mk(28, 1, 0, 2'd0, 48'd0, 0, 2'd2, 1, 0, 48'd0));
    vecs.push_back(mk(32, 1, 0, 2'd0, 48'd0, 0, 2'd3, 1, 0, 48'd0));
    vecs.push_back(mk(35, 1, 0, 2'd0, 48'd0, 0, 2'd3, 0, 0, 48'd0));
    vecs.push_back(mk(36, 1, 0, 2'd0, 48'd0, 0, 2'd3, 0, 1, 48'd0));
    vecs.push_back(mk(37, 1, 0, 2'd0, 48'd0, 0, 2'd3, 0, 0, 48'd0));
    vecs.push_back(mk(38, 1, 1, 2'd2, P2,    1, 2'd3, 0, 0, 48'd0));
    vecs.push_back(mk(40, 1, 0, 2'd0, 48'd0, 0, 2'd0, 1, 0, 48'd0));
    vecs.push_back(mk(44, 1, 0, 2'd0, 48'd0, 0, 2'd1, 1, 0, 48'd0));
    vecs.push_back(mk(45, 1, 1, 2'd1, P1,    0, 2'd1, 0, 0, 48'd0));
    vecs.push_back(mk(46, 1, 1, 2'd1, P1,    0, 2'd1, 0, 0, 48'd0));
    vecs.push_back(mk(47, 1, 1, 2'd1, P1,    0, 2'd1, 0, 0, 48'd0));
    vecs.push_back(mk(48, 1, 1, 2'd1, P1,    1, 2'd2, 1, 0, P2));
    vecs.push_back(mk(51, 1, 0, 2'd0, 48'd0, 0, 2'd2, 0, 0, P2));
    vecs.push_back(mk(52, 1, 0, 2'd0, 48'd0, 0, 2'd3, 1, 0, 48'd0));
    vecs.push_back(mk(56, 1, 0, 2'd0, 48'd0, 0, 2'd3, 0, 1, 48'd0));
    vecs.push_back(mk(60, 1, 0, 2'd0, 48'd0, 0, 2'd0, 1, 0, 48'd0));
    vecs.push_back(mk(64, 1, 0, 2'd0, 48'd0, 0, 2'd1, 1, 0, P1));
    vecs.push_back(mk(65, 0, 0, 2'd0, 48'd0, 0, 2'd1, 0, 0, P1));
    vecs.push_back(mk(68, 0, 0, 2'd0, 48'd0, 0, 2'd2, 1, 0, P2));
    vecs.push_back(mk(72, 0, 0, 2'd0, 48'd0, 0, 2'd3, 1, 0, 48'd0));
    vecs.push_back(mk(76, 0, 0, 2'd0, 48'd0, 0, 2'd3, 0, 1, 48'd0));

    $display("[TB] directed vectors on PRESCALE=%0d", P_A);
    rst_n_a = 1'b0;
    #2;
    checkOutput("in_reset_a", {bus_a.unit, bus_a.porta_tick, bus_a.sweep_done, bus_a.overrun, bus_a.upd_ack, bus_a.pitch_out}, '0);
    resetA();
    vi = 0;
    cur_en = 1'b1;
    for (int k = 0; k <= 76; k++) begin
      if (k > 0) nextCycle();
      cur_req = 1'b0; cur_uu = '0; cur_up = '0;
      if (vi < vecs.size() && vecs[vi].cyc == k) begin
        cur_en = vecs[vi].en; cur_req = vecs[vi].req;
        cur_uu = vecs[vi].uu; cur_up = vecs[vi].up;
      end
      applyStimulus(cur_en, cur_req, cur_uu, cur_up);
      #1;
      if (vi < vecs.size() && vecs[vi].cyc == k) begin
        checkOutput($sformatf("vec_c%0d", k),
                    {bus_a.upd_ack, bus_a.unit, bus_a.porta_tick, bus_a.sweep_done, bus_a.overrun, bus_a.pitch_out},
                    {vecs[vi].ack, vecs[vi].unit, vecs[vi].tick, vecs[vi].done, 1'b0, vecs[vi].pitch});
        vi++;
      end
    end

    // en held low after a sweep: no ticks, requests pile up into an overrun.
    ticks = 0;
    for (int k = 77; k <= 120; k++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 2'd0, 48'd0);
      if (bus_a.porta_tick) ticks++;
    end
    checkOutput("no_tick_en0", 128'(ticks), 128'd0);
    checkOutput("unit_hold_idle", 128'(bus_a.unit), 128'd3);
    checkOutput("overrun_idle", 128'(bus_a.overrun), 128'd1);

    // Reset asserted mid-cycle inside slot 2 of the next sweep.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 2'd0, 48'd0);
    found = 0;
    waited = 0;
    while (!found && waited < 60) begin
      nextCycle();
      waited++;
      if (bus_a.unit == 2'd2 && bus_a.porta_tick) found = 1;
    end
    checkOutput("slot2_reached", 128'(found), 128'd1);
    checkOutput("slot2_pitch", 128'(bus_a.pitch_out), 128'(P2));
    #2;
    rst_n_a = 1'b0;
    #1;
    checkOutput("async_reset_outs",
                {bus_a.unit, bus_a.porta_tick, bus_a.sweep_done, bus_a.overrun, bus_a.upd_ack, bus_a.pitch_out}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n_a = 1'b1;
    ticks = 0;
    for (int k = 1; k <= 36; k++) begin
      nextCycle();
      if (k < 20 && bus_a.porta_tick) ticks++;
      if (k >= 20 && k <= 32 && ((k - 20) % 4) == 0)
        checkOutput($sformatf("post_rst_slot_c%0d", k),
                    {bus_a.porta_tick, bus_a.unit, bus_a.pitch_out},
                    {1'b1, 2'((k - 20) / 4), 48'd0});
    end
    checkOutput("post_rst_no_early_tick", 128'(ticks), 128'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 48'd0);

    $display("[TB] overrun sequence on PRESCALE=%0d", P_B);
    resetB();
    ticks = 0;
    for (int k = 1; k <= 72; k++) begin
      nextCycle();
      bus_b.en = (k >= 40);
      if (k < 40 && bus_b.porta_tick) ticks++;
      if (k == 31) checkOutput("b_overrun_c31", 128'(bus_b.overrun), 128'd0);
      if (k == 39) checkOutput("b_overrun_c39", 128'(bus_b.overrun), 128'd1);
      if (k >= 40 && bus_b.porta_tick) tick_cyc.push_back(k);
      if (k >= 40 && bus_b.sweep_done) done_cyc.push_back(k);
    end
    checkOutput("b_no_tick_en0", 128'(ticks), 128'd0);
    // Held request starts at 41; the count at 47 lands mid-sweep and queues
    // the second sweep, which starts right after sweep_done at 57.
    exp_ticks = '{41, 45, 49, 53, 58, 62, 66, 70};
    checkOutput("b_tick_count", 128'(tick_cyc.size()), 128'(exp_ticks.size()));
    for (int i = 0; i < exp_ticks.size() && i < tick_cyc.size(); i++)
      checkOutput($sformatf("b_tick%0d", i), 128'(tick_cyc[i]), 128'(exp_ticks[i]));
    checkOutput("b_done_count", 128'(done_cyc.size()), 128'd1);
    if (done_cyc.size() > 0) checkOutput("b_done_cyc", 128'(done_cyc[0]), 128'd57);
    checkOutput("b_overrun_sticky", 128'(bus_b.overrun), 128'd1);

    $display("[TB] randomized traffic against reference model");
    resetA();
    modelReset();
    r_en = 1'b1; r_req = 1'b0; r_unit = '0; r_pitch = '0;
    for (int k = 0; k < 1500; k++) begin
      if (k > 0) nextCycle();
      checkOutput($sformatf("rnd_regs_c%0d", k),
                  {bus_a.unit, bus_a.porta_tick, bus_a.sweep_done, bus_a.overrun, bus_a.pitch_out},
                  {m_unit, m_tick, m_done, m_overrun, m_pitch});
      if ((k % 64) == 0) r_en = ($urandom_range(0, 3) != 0);
      if (!r_req && $urandom_range(0, 2) == 0) begin
        r_req   = 1'b1;
        r_unit  = 2'($urandom_range(0, 3));
        r_pitch = {16'($urandom), $urandom};
      end
      applyStimulus(r_en, r_req, r_unit, r_pitch);
      #1;
      e_ack = modelAck(r_req, r_unit);
      checkOutput($sformatf("rnd_ack_c%0d", k), 128'(bus_a.upd_ack), 128'(e_ack));
      modelEdge(r_en, e_ack, r_unit, r_pitch);
      if (e_ack) r_req = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
